home_status_decoder: RTL and testbench

//  Receive-side decoder for the 3-bit display code produced by the home-automation sensor controller.
//  - Turns the code stream into discrete events and held (stretched) per-actuator indicator LEDs.
//  - Provides a sticky alarm latch with a saturating alarm counter, an illegal-code flag and a
//    7-segment glyph of the current code.
//  - Sits between the controller's display bus and the front-panel status logic.

---
 rtl/home_status_decoder.sv | 108 ++++++++++
 tb/tb_home_status_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/home_status_decoder.sv
// Receive-side decoder for the controller's 3-bit display code: one-shot events, stretched
// per-actuator indicators, sticky alarm/illegal flags, saturating alarm counter and a 7-segment glyph.
module home_status_decoder #(
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [2:0]       display,
  input  logic             ack,
  output logic             evt_valid,
  output logic [2:0]       evt_code,
  output logic [5:0]       led,
  output logic             alarm_latched,
  output logic [CNT_W-1:0] alarm_count,
  output logic             err,
  output logic [6:0]       seg
);

  localparam int              TW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0]   HOLD_T   = TW'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [2:0] CODE_NONE    = 3'b000;
  localparam logic [2:0] CODE_ALARM   = 3'b011;
  localparam logic [2:0] CODE_ILLEGAL = 3'b111;

  logic [2:0]       disp_q, prev_q;
  logic             evt_valid_q, evt_valid_d;
  logic [2:0]       evt_code_q, evt_code_d;
  logic [5:0]       led_q, led_d;
  logic             alarm_q, alarm_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [6:0]       seg_q, seg_d;
  logic [TW-1:0]    timer_q [6];
  logic [TW-1:0]    timer_d [6];
  logic [5:0]       hit;
  logic             alarm_evt;

  always_comb begin
    evt_valid_d = (disp_q != CODE_NONE) && (disp_q != CODE_ILLEGAL) && (disp_q != prev_q);
    evt_code_d  = evt_valid_d ? disp_q : evt_code_q;
    alarm_evt   = evt_valid_d && (disp_q == CODE_ALARM);

    // A set in the same cycle as ack takes priority over the clear.
    alarm_d = alarm_evt ? 1'b1 : (ack ? 1'b0 : alarm_q);
    err_d   = (disp_q == CODE_ILLEGAL) ? 1'b1 : (ack ? 1'b0 : err_q);
    count_d = (alarm_evt && (count_q != CNT_MAX)) ? count_q + CNT_W'(1) : count_q;

    // Timer i tracks code i+1; its LED sits at bit 5-i. The LED is lit while the code is
    // present and for HOLD_CYCLES cycles after the last sighting.
    hit   = '0;
    led_d = '0;
    for (int i = 0; i < 6; i++) begin
      hit[i]        = (disp_q == 3'(i + 1));
      timer_d[i]    = hit[i] ? HOLD_T :
                      ((timer_q[i] != '0) ? timer_q[i] - TW'(1) : '0);
      led_d[5 - i]  = hit[i] || (timer_q[i] != '0);
    end

    case (disp_q)
      3'b001:  seg_d = 7'b1110001;
      3'b010:  seg_d = 7'b1010000;
      3'b011:  seg_d = 7'b1110111;
      3'b100:  seg_d = 7'b0111110;
      3'b101:  seg_d = 7'b1110110;
      3'b110:  seg_d = 7'b0111001;
      3'b111:  seg_d = 7'b1000000;
      default: seg_d = 7'b0000000;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      disp_q      <= '0;
      prev_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      led_q       <= '0;
      alarm_q     <= 1'b0;
      count_q     <= '0;
      err_q       <= 1'b0;
      seg_q       <= '0;
      for (int i = 0; i < 6; i++) timer_q[i] <= '0;
    end else begin
      disp_q      <= display;
      prev_q      <= disp_q;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      led_q       <= led_d;
      alarm_q     <= alarm_d;
      count_q     <= count_d;
      err_q       <= err_d;
      seg_q       <= seg_d;
      for (int i = 0; i < 6; i++) timer_q[i] <= timer_d[i];
    end
  end

  assign evt_valid     = evt_valid_q;
  assign evt_code      = evt_code_q;
  assign led           = led_q;
  assign alarm_latched = alarm_q;
  assign alarm_count   = count_q;
  assign err           = err_q;
  assign seg           = seg_q;

endmodule

// File: tb/tb_home_status_decoder.sv
// Bench for home_status_decoder: directed and random display streams against a history-based
// reference model; a second instance runs with a short hold and a 2-bit alarm counter.
module tb_home_status_decoder;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [2:0] display = 3'b000;
  logic       ack = 1'b0;

  logic       evt_valid, evt_valid2;
  logic [2:0] evt_code, evt_code2;
  logic [5:0] led, led2;
  logic       alarm_latched, alarm_latched2;
  logic [7:0] alarm_count;
  logic [1:0] alarm_count2;
  logic       err, err2;
  logic [6:0] seg, seg2;

  always #5 Clk = ~Clk;

  home_status_decoder #(.HOLD_CYCLES(16), .CNT_W(8)) u_dut (
    .Clk(Clk), .Rst(Rst), .display(display), .ack(ack),
    .evt_valid(evt_valid), .evt_code(evt_code), .led(led),
    .alarm_latched(alarm_latched), .alarm_count(alarm_count),
    .err(err), .seg(seg)
  );

  home_status_decoder #(.HOLD_CYCLES(4), .CNT_W(2)) u_sat (
    .Clk(Clk), .Rst(Rst), .display(display), .ack(ack),
    .evt_valid(evt_valid2), .evt_code(evt_code2), .led(led2),
    .alarm_latched(alarm_latched2), .alarm_count(alarm_count2),
    .err(err2), .seg(seg2)
  );

  // Reference model: the sampled code history plus the cycle each code was last seen.
  localparam int NONE = -100000;
  int         n_cmp = 0;
  int         n_err = 0;
  int         t = 0;
  int         last_seen [1:6];
  int         s1 = 0, s2 = 0;
  logic       e_evt = 0, e_lat = 0, e_err = 0;
  logic [2:0] e_code = 0;
  logic [6:0] e_seg = 0;
  logic [5:0] e_led = 0, e_led2 = 0;
  int         e_cnt = 0, e_cnt2 = 0;

  function automatic logic [6:0] glyph(input int c);
    case (c)
      1: return 7'b1110001;
      2: return 7'b1010000;
      3: return 7'b1110111;
      4: return 7'b0111110;
      5: return 7'b1110110;
      6: return 7'b0111001;
      7: return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_update(input int d, input logic a, input logic r);
    bit alarm;
    if (r) begin
      s1 = 0; s2 = 0;
      for (int c = 1; c <= 6; c++) last_seen[c] = NONE;
      e_evt = 0; e_code = 0; e_lat = 0; e_err = 0; e_seg = 0;
      e_led = 0; e_led2 = 0; e_cnt = 0; e_cnt2 = 0;
    end else begin
      e_evt = (s1 != 0) && (s1 != 7) && (s1 != s2);
      if (e_evt) e_code = 3'(s1);
      alarm = e_evt && (s1 == 3);
      e_lat = alarm ? 1'b1 : (a ? 1'b0 : e_lat);
      e_err = (s1 == 7) ? 1'b1 : (a ? 1'b0 : e_err);
      if (alarm) begin
        e_cnt  = (e_cnt  < 255) ? e_cnt + 1  : 255;
        e_cnt2 = (e_cnt2 < 3)   ? e_cnt2 + 1 : 3;
      end
      e_seg = glyph(s1);
      if (s1 >= 1 && s1 <= 6) last_seen[s1] = t - 1;
      for (int c = 1; c <= 6; c++) begin
        e_led[6 - c]  = (t - 1 - last_seen[c]) <= 16;
        e_led2[6 - c] = (t - 1 - last_seen[c]) <= 4;
      end
      s2 = s1;
      s1 = d;
    end
  endtask

  task automatic step(input logic [2:0] d, input logic a, input logic r);
    display = d;
    ack     = a;
    Rst     = r;
    @(posedge Clk);
    #1;
    t++;
    model_update(int'(d), a, r);
    check("evt_valid",     evt_valid,      e_evt);
    check("evt_code",      evt_code,       e_code);
    check("led",           led,            e_led);
    check("alarm_latched", alarm_latched,  e_lat);
    check("alarm_count",   alarm_count,    e_cnt);
    check("err",           err,            e_err);
    check("seg",           seg,            e_seg);
    check("sat_evt_valid", evt_valid2,     e_evt);
    check("sat_led",       led2,           e_led2);
    check("sat_alarm_cnt", alarm_count2,   e_cnt2);
    check("sat_latched",   alarm_latched2, e_lat);
  endtask

  initial begin
    int code;
    int len;
    for (int c = 1; c <= 6; c++) last_seen[c] = NONE;

    // Reset with idle display
    step(3'b000, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b1);
    check("reset_seg_zero", seg, 7'b0000000);

    // Single-cycle front door code, then idle long enough for the hold to expire
    step(3'b001, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) step(3'b000, 1'b0, 1'b0);

    // Three alarms separated by idle; ack coincides with the third pulse, then ack alone
    step(3'b011, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    step(3'b011, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    step(3'b011, 1'b0, 1'b0);
    step(3'b000, 1'b1, 1'b0);
    check("latch_after_ack_with_set", alarm_latched, 1'b1);
    step(3'b000, 1'b0, 1'b0);
    step(3'b000, 1'b1, 1'b0);
    check("latch_cleared_by_ack", alarm_latched, 1'b0);
    check("count_kept_after_ack", alarm_count, 8'd3);

    // Alarm held constant gives one pulse; alarm to heater gives a heater pulse
    for (int i = 0; i < 4; i++) step(3'b011, 1'b0, 1'b0);
    step(3'b101, 1'b0, 1'b0);
    step(3'b101, 1'b0, 1'b0);

    // Enough alarm events to saturate both counters
    for (int i = 0; i < 258; i++) begin
      step(3'b011, 1'b0, 1'b0);
      step(3'b000, 1'b0, 1'b0);
    end
    check("count_saturated_8b", alarm_count, 8'd255);
    check("count_saturated_2b", alarm_count2, 2'd3);

    // Illegal code: err set, no event, glyph dash; ack clears
    for (int i = 0; i < 20; i++) step(3'b000, 1'b0, 1'b0);
    step(3'b111, 1'b0, 1'b0);
    step(3'b111, 1'b0, 1'b0);
    check("illegal_seg", seg, 7'b1000000);
    check("illegal_no_led", led, 6'b000000);
    step(3'b000, 1'b1, 1'b0);
    step(3'b000, 1'b1, 1'b0);
    check("err_cleared", err, 1'b0);

    // Heater held, reset mid-hold while the code stays present
    for (int i = 0; i < 15; i++) step(3'b101, 1'b0, 1'b0);
    step(3'b101, 1'b0, 1'b1);
    check("reset_clears_led", led, 6'b000000);
    for (int i = 0; i < 15; i++) step(3'b101, 1'b0, 1'b0);
    check("heater_relit", led, 6'b000010);
    for (int i = 0; i < 20; i++) step(3'b000, 1'b0, 1'b0);

    // Random runs of codes with sporadic ack and reset
    for (int k = 0; k < 150; k++) begin
      code = $urandom_range(0, 7);
      len  = $urandom_range(1, 6);
      for (int i = 0; i < len; i++)
        step(3'(code), ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
